// File: rtl/wasca_spi_slave.sv
// SPI mode-0 slave endpoint (16-bit, MSB first) with a CPU register port that uses the on-chip master's addressing.
// SCLK, SS_n and MOSI are oversampled in clk; edges become single-cycle pulses, so nothing is clocked by SCLK.

module wasca_spi_slave #(
  parameter int DATABITS    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                SCLK,
  input  logic                SS_n,
  input  logic                MOSI,
  output logic                MISO,
  output logic                MISO_oe,
  input  logic                spi_select,
  input  logic [2:0]          mem_addr,
  input  logic                read_n,
  input  logic                write_n,
  input  logic [DATABITS-1:0] data_from_cpu,
  output logic [DATABITS-1:0] data_to_cpu,
  output logic                irq,
  output logic                dataavailable,
  output logic                readyfordata,
  output logic [1:0]          dbg_state_o
);

  localparam int CW = $clog2(DATABITS);

  // S_LOCK holds off frame detection after reset until SS_n is seen high, so a
  // master still holding SS_n low cannot start a frame mid-word.
  typedef enum logic [1:0] {
    S_LOCK   = 2'd0,
    S_IDLE   = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, ss_prev_q;

  logic [DATABITS-1:0] rx_shift_q, rx_shift_d;
  logic [DATABITS-1:0] rx_hold_q, rx_hold_d;
  logic [DATABITS-1:0] tx_hold_q, tx_hold_d;
  logic [DATABITS-1:0] tx_shift_q, tx_shift_d;
  logic [DATABITS-1:0] data_to_cpu_q, data_to_cpu_d;
  logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [5:0]          ctrl_q, ctrl_d;
  logic rrdy_q, rrdy_d, roe_q, roe_d, toe_q, toe_d, tur_q, tur_d;
  logic tx_primed_q, tx_primed_d, reload_q, reload_d;
  logic irq_q, irq_d, miso_q, miso_d, miso_oe_q, miso_oe_d;

  logic sclk_s, ss_s, mosi_s;
  logic active, frame_start, abort, sclk_rise, sclk_fall, word_done, load_ev;
  logic rd_any, rd_rx, wr_tx, wr_st, wr_ctrl, toe_set;
  logic [DATABITS-1:0] rx_word, status_w, ctrl_word;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign active      = (state_q == S_ACTIVE);
  assign frame_start = (state_q == S_IDLE) & ss_prev_q & ~ss_s;
  assign abort       = active & ss_s;
  assign sclk_rise   = active & ~ss_s & sclk_s & ~sclk_prev_q;
  assign sclk_fall   = active & ~ss_s & ~sclk_s & sclk_prev_q;
  assign word_done   = sclk_rise & (bit_cnt_q == CW'(DATABITS - 1));
  assign load_ev     = frame_start | (sclk_fall & reload_q);
  assign rx_word     = {rx_shift_q[DATABITS-2:0], mosi_s};

  // Register port: an access happens in every clk cycle where spi_select is high
  // with read_n or write_n low; there is no wait state and no acknowledge.
  assign rd_any  = spi_select & ~read_n;
  assign rd_rx   = rd_any & (mem_addr == 3'd0);
  assign wr_tx   = spi_select & ~write_n & (mem_addr == 3'd1);
  assign wr_st   = spi_select & ~write_n & (mem_addr == 3'd2);
  assign wr_ctrl = spi_select & ~write_n & (mem_addr == 3'd3);
  assign toe_set = wr_tx & tx_primed_q & ~load_ev;

  always_comb begin
    status_w    = '0;
    status_w[8] = roe_q | toe_q | tur_q;
    status_w[7] = rrdy_q;
    status_w[6] = ~tx_primed_q;
    status_w[5] = ~tx_primed_q & ~active;
    status_w[4] = tur_q;
    status_w[3] = roe_q;
    status_w[2] = toe_q;
    ctrl_word      = '0;
    ctrl_word[8:3] = ctrl_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOCK:   if (ss_s)        state_d = S_IDLE;
      S_IDLE:   if (frame_start) state_d = S_ACTIVE;
      S_ACTIVE: if (ss_s)        state_d = S_IDLE;
      default:                   state_d = S_LOCK;
    endcase
  end

  always_comb begin
    rx_shift_d    = rx_shift_q;
    rx_hold_d     = rx_hold_q;
    tx_hold_d     = tx_hold_q;
    tx_shift_d    = tx_shift_q;
    data_to_cpu_d = data_to_cpu_q;
    bit_cnt_d     = bit_cnt_q;
    ctrl_d        = ctrl_q;
    rrdy_d        = rrdy_q;
    tx_primed_d   = tx_primed_q;
    reload_d      = reload_q;

    if (sclk_rise) begin
      rx_shift_d = rx_word;
      bit_cnt_d  = bit_cnt_q + 1'b1;
    end
    if (word_done) begin
      rx_hold_d = rx_word;
      bit_cnt_d = '0;
      reload_d  = 1'b1;
    end
    if (sclk_fall & reload_q) reload_d = 1'b0;
    if (frame_start | abort) begin
      bit_cnt_d = '0;
      reload_d  = 1'b0;
    end

    if (load_ev)        tx_shift_d = tx_primed_q ? tx_hold_q : '0;
    else if (sclk_fall) tx_shift_d = tx_shift_q << 1;
    else if (abort)     tx_shift_d = '0;

    // A write landing on the same cycle as a load refills the just-emptied holding register.
    if (load_ev & tx_primed_q) tx_primed_d = 1'b0;
    if (wr_tx & (~tx_primed_q | load_ev)) begin
      tx_hold_d   = data_from_cpu;
      tx_primed_d = 1'b1;
    end

    if (rd_rx)     rrdy_d = 1'b0;
    if (word_done) rrdy_d = 1'b1;

    roe_d = (roe_q & ~wr_st) | (word_done & rrdy_q);
    tur_d = (tur_q & ~wr_st) | (load_ev & ~tx_primed_q);
    toe_d = (toe_q & ~wr_st) | toe_set;

    if (wr_ctrl) ctrl_d = data_from_cpu[8:3];

    if (rd_any) begin
      case (mem_addr)
        3'd0:    data_to_cpu_d = rx_hold_q;
        3'd2:    data_to_cpu_d = status_w;
        3'd3:    data_to_cpu_d = ctrl_word;
        default: data_to_cpu_d = '0;
      endcase
    end

    irq_d     = |(status_w[8:3] & ctrl_q);
    miso_d    = active & ~ss_s & tx_shift_q[DATABITS-1];
    miso_oe_d = (state_q != S_LOCK) & ~ss_s;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_LOCK;
      sclk_sync_q   <= '0;
      ss_sync_q     <= '0;
      mosi_sync_q   <= '0;
      sclk_prev_q   <= 1'b0;
      ss_prev_q     <= 1'b0;
      rx_shift_q    <= '0;
      rx_hold_q     <= '0;
      tx_hold_q     <= '0;
      tx_shift_q    <= '0;
      data_to_cpu_q <= '0;
      bit_cnt_q     <= '0;
      ctrl_q        <= '0;
      rrdy_q        <= 1'b0;
      roe_q         <= 1'b0;
      toe_q         <= 1'b0;
      tur_q         <= 1'b0;
      tx_primed_q   <= 1'b0;
      reload_q      <= 1'b0;
      irq_q         <= 1'b0;
      miso_q        <= 1'b0;
      miso_oe_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sclk_sync_q   <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      ss_sync_q     <= {ss_sync_q[SYNC_STAGES-2:0], SS_n};
      mosi_sync_q   <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      sclk_prev_q   <= sclk_s;
      ss_prev_q     <= ss_s;
      rx_shift_q    <= rx_shift_d;
      rx_hold_q     <= rx_hold_d;
      tx_hold_q     <= tx_hold_d;
      tx_shift_q    <= tx_shift_d;
      data_to_cpu_q <= data_to_cpu_d;
      bit_cnt_q     <= bit_cnt_d;
      ctrl_q        <= ctrl_d;
      rrdy_q        <= rrdy_d;
      roe_q         <= roe_d;
      toe_q         <= toe_d;
      tur_q         <= tur_d;
      tx_primed_q   <= tx_primed_d;
      reload_q      <= reload_d;
      irq_q         <= irq_d;
      miso_q        <= miso_d;
      miso_oe_q     <= miso_oe_d;
    end
  end

  assign MISO          = miso_q;
  assign MISO_oe       = miso_oe_q;
  assign data_to_cpu   = data_to_cpu_q;
  assign irq           = irq_q;
  assign dataavailable = rrdy_q;
  assign readyfordata  = ~tx_primed_q;
  assign dbg_state_o   = state_q;

endmodule
